// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample handshake and I2S serial lines of the I2S transmitter.
//
//   lft_chnnl / rght_chnnl : parallel left/right sample from the datapath
//   smpl_vld               : 1-clk strobe, samples valid
//   smpl_req               : 1-clk pulse, holding register consumed
//   undrflw                : 1-clk pulse, frame started without a fresh sample
//   I2S_sclk/I2S_ws/I2S_data : serial bit clock, word select, serial data
//
// Modport "master" is the transmitter itself (it is the I2S clock master and
// consumes samples); "slave" is the sample source / serial-line observer.
interface i2s_tx_if #(
    parameter int unsigned DATA_W = 24
) ();
    logic [DATA_W-1:0] lft_chnnl;
    logic [DATA_W-1:0] rght_chnnl;
    logic              smpl_vld;
    logic              smpl_req;
    logic              undrflw;
    logic              I2S_sclk;
    logic              I2S_ws;
    logic              I2S_data;

    modport master (
        input  lft_chnnl,
        input  rght_chnnl,
        input  smpl_vld,
        output smpl_req,
        output undrflw,
        output I2S_sclk,
        output I2S_ws,
        output I2S_data
    );

    modport slave (
        output lft_chnnl,
        output rght_chnnl,
        output smpl_vld,
        input  smpl_req,
        input  undrflw,
        input  I2S_sclk,
        input  I2S_ws,
        input  I2S_data
    );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter.
//
// Takes parallel DATA_W-bit left/right samples through a holding register and
// serialises them: WS low = left, MSB first, one SCLK delay after each WS edge,
// data launched on SCLK fall. Each slot is SLOT_BITS SCLK periods; unused
// trailing positions are zero.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : i2s_tx_if.master -- sample handshake (lft_chnnl, rght_chnnl,
//          smpl_vld in; smpl_req, undrflw out) and serial lines
//          (I2S_sclk, I2S_ws, I2S_data out)
//
// Parameters: HALF_PER >= 2 clk cycles per SCLK half period,
//             DATA_W sample width, SLOT_BITS >= DATA_W.
module i2s_tx #(
    parameter int unsigned HALF_PER  = 16,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned SLOT_BITS = 24
) (
    input  logic     clk,
    input  logic     rst,
    i2s_tx_if.master bus
);

    localparam int unsigned FRAME = 2 * SLOT_BITS;
    localparam int unsigned PW    = $clog2(FRAME);
    localparam int unsigned DW    = $clog2(HALF_PER);
    localparam int unsigned IW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DW-1:0] DivLast = DW'(HALF_PER - 1);
    localparam logic [PW-1:0] PosLast = PW'(FRAME - 1);
    localparam logic [PW-1:0] PosWs   = PW'(SLOT_BITS);

    // Divider and serial state
    logic [DW-1:0]     div_q, div_d;
    logic              sclk_q, sclk_d;
    logic [PW-1:0]     p_q, p_d;
    logic              ws_q, ws_d;
    logic              data_q, data_d;

    // Sample path
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [DATA_W-1:0] tx_l_q, tx_l_d;
    logic [DATA_W-1:0] tx_r_q, tx_r_d;
    logic              hold_full_q, hold_full_d;
    logic              armed_q, armed_d;
    logic              req_q, req_d;
    logic              undr_q, undr_d;

    // Events
    logic              div_wrap;
    logic              fall_ev;
    logic              snap;
    logic [PW-1:0]     p_nxt;
    logic              bit_nxt;
    int unsigned       pos;

    always_comb begin
        div_wrap = (div_q == DivLast);
        fall_ev  = div_wrap & sclk_q;
        p_nxt    = (p_q == PosLast) ? '0 : p_q + 1'b1;
        snap     = fall_ev & (p_nxt == '0);
    end

    // Serial bit for the position being entered. Position 0 is treated as
    // FRAME so that, when DATA_W == SLOT_BITS, the right LSB lands there. It is
    // read from tx_r_q before the snapshot in the same clk replaces it.
    always_comb begin
        pos     = (p_nxt == '0) ? FRAME : 32'(p_nxt);
        bit_nxt = 1'b0;
        if (pos >= 1 && pos <= DATA_W) begin
            bit_nxt = tx_l_q[IW'(DATA_W - pos)];
        end else if (pos > SLOT_BITS && pos <= SLOT_BITS + DATA_W) begin
            bit_nxt = tx_r_q[IW'(SLOT_BITS + DATA_W - pos)];
        end
    end

    always_comb begin
        div_d       = div_wrap ? '0 : div_q + 1'b1;
        sclk_d      = sclk_q ^ div_wrap;
        p_d         = p_q;
        ws_d        = ws_q;
        data_d      = data_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        tx_l_d      = tx_l_q;
        tx_r_d      = tx_r_q;
        hold_full_d = hold_full_q;
        armed_d     = armed_q;
        req_d       = 1'b0;
        undr_d      = 1'b0;

        if (fall_ev) begin
            p_d    = p_nxt;
            ws_d   = (p_nxt >= PosWs);
            data_d = bit_nxt;
        end

        if (snap) begin
            req_d       = 1'b1;
            hold_full_d = 1'b0;
            if (bus.smpl_vld) begin
                // Bypass: the strobed sample goes straight out; it also becomes
                // the value repeated on a later underflow.
                tx_l_d   = bus.lft_chnnl;
                tx_r_d   = bus.rght_chnnl;
                hold_l_d = bus.lft_chnnl;
                hold_r_d = bus.rght_chnnl;
                armed_d  = 1'b1;
            end else begin
                // Holding register keeps its value, so an underflow repeats it.
                tx_l_d = hold_l_q;
                tx_r_d = hold_r_q;
                undr_d = ~hold_full_q & armed_q;
            end
        end else if (bus.smpl_vld) begin
            hold_l_d    = bus.lft_chnnl;
            hold_r_d    = bus.rght_chnnl;
            hold_full_d = 1'b1;
            armed_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            sclk_q      <= 1'b0;
            p_q         <= PosLast;
            ws_q        <= 1'b1;
            data_q      <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            tx_l_q      <= '0;
            tx_r_q      <= '0;
            hold_full_q <= 1'b0;
            armed_q     <= 1'b0;
            req_q       <= 1'b0;
            undr_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            p_q         <= p_d;
            ws_q        <= ws_d;
            data_q      <= data_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            tx_l_q      <= tx_l_d;
            tx_r_q      <= tx_r_d;
            hold_full_q <= hold_full_d;
            armed_q     <= armed_d;
            req_q       <= req_d;
            undr_q      <= undr_d;
        end
    end

    assign bus.I2S_sclk = sclk_q;
    assign bus.I2S_ws   = ws_q;
    assign bus.I2S_data = data_q;
    assign bus.smpl_req = req_q;
    assign bus.undrflw  = undr_q;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_tx_if #(.DATA_W(24)) bus ();
    i2s_tx_if #(.DATA_W(24)) bus1 ();

    i2s_tx #(.HALF_PER(16), .DATA_W(24), .SLOT_BITS(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    i2s_tx #(.HALF_PER(16), .DATA_W(24), .SLOT_BITS(32)) dut_pad (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        bit          vld;
        bit          dbl;
        bit          coinc;
        logic [23:0] l_in;
        logic [23:0] r_in;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        bit          exp_undr;
    } vec_t;

    vec_t vecs [7];

    int   n_chk  = 0;
    int   n_pass = 0;
    logic prev_sclk, prev1;
    logic rose, rose1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        prev_sclk = bus.I2S_sclk;
        prev1     = bus1.I2S_sclk;
        @(posedge clk);
        #1;
        rose  = !prev_sclk && bus.I2S_sclk;
        rose1 = !prev1 && bus1.I2S_sclk;
    endtask

    // Reset for 3 clks, then check divider/first-snapshot timing after release.
    task automatic timing_check(input string tag, input bit do_load,
                                input logic [23:0] l, input logic [23:0] r);
        int   t_rise = 0;
        int   t_fall = 0;
        int   early  = 0;
        logic [2:0] snap_v = 3'b111;
        logic [2:0] p0_v   = 3'b011;
        rst = 1'b1;
        tick();
        check({tag, "_reset_outputs"},
              64'({bus.I2S_sclk, bus.I2S_ws, bus.I2S_data, bus.smpl_req, bus.undrflw}),
              64'(5'b01000));
        tick();
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 100 && t_fall == 0; n++) begin
            if (do_load && n == 5) begin
                bus.lft_chnnl  = l;
                bus.rght_chnnl = r;
                bus.smpl_vld   = 1'b1;
            end
            tick();
            bus.smpl_vld = 1'b0;
            if (t_rise == 0 && bus.I2S_sclk) t_rise = n;
            if (t_rise != 0 && !bus.I2S_sclk) begin
                t_fall = n;
                snap_v = {bus.I2S_ws, bus.smpl_req, bus.undrflw};
            end else if (!bus.I2S_ws || bus.smpl_req || bus.undrflw) begin
                early++;
            end
        end
        check({tag, "_first_rise_clk"}, 64'(t_rise), 64'(16));
        check({tag, "_first_fall_clk"}, 64'(t_fall), 64'(32));
        check({tag, "_snap_ws_req_undr"}, 64'(snap_v), 64'(3'b010));
        check({tag, "_quiet_before_fall"}, 64'(early), 64'(0));
        for (int n = 0; n < 40; n++) begin
            tick();
            if (rose) begin
                p0_v = {1'b1, bus.I2S_data, bus.I2S_ws};
                break;
            end
        end
        check({tag, "_p0_bit"}, 64'(p0_v), 64'(3'b100));
    endtask

    // Entered just after a p=0 rise; collects p=1..47 plus the next p=0 bit.
    task automatic run_frame(input string tag, input vec_t v);
        logic [23:0] got_l  = 'x;
        logic [23:0] got_r  = 'x;
        int          p      = 0;
        int          ws_err = 0;
        int          stray  = 0;
        int          budget = 0;
        logic [2:0]  snap_v;
        if (v.vld && !v.coinc) begin
            if (v.dbl) begin
                bus.lft_chnnl  = 24'hFFFFFF;
                bus.rght_chnnl = 24'hFFFFFF;
                bus.smpl_vld   = 1'b1;
                tick();
                bus.smpl_vld   = 1'b0;
                tick();
            end
            bus.lft_chnnl  = v.l_in;
            bus.rght_chnnl = v.r_in;
            bus.smpl_vld   = 1'b1;
            tick();
            bus.smpl_vld   = 1'b0;
        end
        while (p < 47 && budget < 2000) begin
            tick();
            budget++;
            if (bus.smpl_req || bus.undrflw) stray++;
            if (rose) begin
                p++;
                if (bus.I2S_ws !== (p >= 24)) ws_err++;
                if (p <= 24) got_l[5'(24 - p)] = bus.I2S_data;
                else got_r[5'(48 - p)] = bus.I2S_data;
            end
        end
        // The snapshot fall comes HALF_PER clks after the p=47 rise.
        for (int i = 1; i <= 16; i++) begin
            if (v.coinc && i == 16) begin
                bus.lft_chnnl  = v.l_in;
                bus.rght_chnnl = v.r_in;
                bus.smpl_vld   = 1'b1;
            end
            tick();
            if (i < 16 && (bus.smpl_req || bus.undrflw)) stray++;
        end
        bus.smpl_vld = 1'b0;
        snap_v = {bus.I2S_sclk, bus.smpl_req, bus.undrflw};
        check({tag, "_snap_sclk_req_undr"}, 64'(snap_v), 64'({2'b01, v.exp_undr}));
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.smpl_req || bus.undrflw) stray++;
            if (rose) begin
                got_r[0] = bus.I2S_data;
                if (bus.I2S_ws !== 1'b0) ws_err++;
                break;
            end
        end
        check({tag, "_left"}, 64'(got_l), 64'(v.exp_l));
        check({tag, "_right"}, 64'(got_r), 64'(v.exp_r));
        check({tag, "_ws_errors"}, 64'(ws_err), 64'(0));
        check({tag, "_stray_pulses"}, 64'(stray), 64'(0));
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation timed out at %0t", $time);
        $fatal(1);
    end

    initial begin
        int          cnt;
        int          budget;
        int          p;
        int          frame_len;
        bit          found;
        logic [63:0] pad_d, pad_w, exp_d, exp_w;

        bus.lft_chnnl   = '0;
        bus.rght_chnnl  = '0;
        bus.smpl_vld    = 1'b0;
        bus1.lft_chnnl  = '0;
        bus1.rght_chnnl = '0;
        bus1.smpl_vld   = 1'b0;

        //           vld   dbl   coinc l_in        r_in        exp_l       exp_r       undr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 24'h123456, 24'h654321, 24'hA5C3F1, 24'h5A3C0F, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 24'h123456, 24'h654321, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 24'hDEADBE, 24'h0BEEF1, 24'h123456, 24'h654321, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 24'h000001, 24'h800000, 24'hDEADBE, 24'h0BEEF1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 24'h000001, 24'h800000, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 24'h00000F, 24'hF00000, 24'h000001, 24'h800000, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 24'h00000F, 24'hF00000, 1'b1};

        timing_check("por", 1'b1, 24'hA5C3F1, 24'h5A3C0F);

        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("frame%0d", i), vecs[i]);
        end

        // Reset in the middle of the left slot (at left bit 10).
        cnt    = 0;
        budget = 0;
        while (cnt < 10 && budget < 1000) begin
            tick();
            budget++;
            if (rose) cnt++;
        end
        check("midrst_reached_bit10", 64'(cnt), 64'(10));
        timing_check("midrst", 1'b0, 24'h0, 24'h0);
        run_frame("unarmed", '{1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0});

        // SLOT_BITS=32 instance: all-ones samples show the zero padding.
        bus1.lft_chnnl  = '1;
        bus1.rght_chnnl = '1;
        bus1.smpl_vld   = 1'b1;
        tick();
        bus1.smpl_vld   = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (bus1.smpl_req) begin
                found = 1'b1;
                break;
            end
        end
        check("pad_first_snap_undr", 64'({found, bus1.undrflw}), 64'(2'b10));
        pad_d     = '0;
        pad_w     = '0;
        p         = 0;
        frame_len = 0;
        found     = 1'b0;
        while (frame_len < 3000) begin
            tick();
            frame_len++;
            if (rose1 && p < 64) begin
                pad_d[6'(p)] = bus1.I2S_data;
                pad_w[6'(p)] = bus1.I2S_ws;
                p++;
            end
            if (bus1.smpl_req) begin
                found = 1'b1;
                break;
            end
        end
        exp_d = '0;
        exp_w = '0;
        for (int k = 0; k < 64; k++) begin
            exp_d[6'(k)] = (k >= 1 && k <= 24) || (k >= 33 && k <= 56);
            exp_w[6'(k)] = (k >= 32);
        end
        check("pad_data", pad_d, exp_d);
        check("pad_ws", pad_w, exp_w);
        check("pad_rises", 64'(p), 64'(64));
        check("pad_frame_clks", 64'(frame_len), 64'(2048));
        check("pad_second_snap_undr", 64'({found, bus1.undrflw}), 64'(2'b11));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
